// File: rtl/sw_debounce_edge_pkg.sv
// Board timing constants shared by timing blocks, plus the per-channel debouncer output record.
package sw_debounce_edge_pkg;

    localparam int BOARD_CLK_HZ = 50_000_000;
    localparam int TICK_DIV_1MS = BOARD_CLK_HZ / 1000;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } ch_out_t;

endpackage

// File: rtl/sw_debounce_edge_if.sv
// Switch conditioning bus: raw inputs in, clean levels, edge pulses and sample tick out.
interface sw_debounce_edge_if #(
    parameter int N_SW = 3
);
    logic [N_SW-1:0] sw_in;
    logic [N_SW-1:0] sw_level;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic            tick;

    modport master (output sw_in, input sw_level, sw_rise, sw_fall, tick);
    modport slave  (input sw_in, output sw_level, sw_rise, sw_fall, tick);
endinterface

// File: rtl/sw_debounce_edge_ch.sv
// One switch channel: polarity fix, 2-flop synchroniser, tick-counted stability filter,
// registered level with single-cycle rise/fall pulses.
module debounce_ch
    import sw_debounce_edge_pkg::*;
#(
    parameter int STABLE_TICKS = 8,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_tick,
    input  logic    i_sw,
    output ch_out_t o_out
);
    localparam int             CW     = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(STABLE_TICKS - 1);

    logic          w_sw;
    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    ch_out_t       r_out;

    assign w_sw = ACTIVE_LOW ? ~i_sw : i_sw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= w_sw;
            r_s2 <= r_s1;
        end
    end

    // Any clk of agreement restarts the stability count, tick or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_out <= '0;
        end else begin
            r_out.rise <= 1'b0;
            r_out.fall <= 1'b0;
            if (r_s2 == r_out.level) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == C_LAST) begin
                    r_out.level <= r_s2;
                    r_out.rise  <= r_s2;
                    r_out.fall  <= ~r_s2;
                    r_cnt       <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/sw_debounce_edge.sv
// Switch input conditioner: shared sample-tick prescaler feeding N_SW independent debounce channels.
module sw_debounce_edge
    import sw_debounce_edge_pkg::*;
#(
    parameter int N_SW         = 3,
    parameter int TICK_DIV     = TICK_DIV_1MS,
    parameter int STABLE_TICKS = 8,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    sw_debounce_edge_if.slave  sw_bus
);
    localparam int             PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  P_PRE  = PW'(TICK_DIV - 2);

    logic [PW-1:0]   r_pcnt;
    logic            r_tick;
    ch_out_t         w_ch [N_SW];
    logic [N_SW-1:0] w_level;
    logic [N_SW-1:0] w_rise;
    logic [N_SW-1:0] w_fall;

    // tick is registered one count early so it is high exactly while r_pcnt == TICK_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pcnt <= (r_pcnt == P_LAST) ? '0 : r_pcnt + PW'(1);
            r_tick <= (r_pcnt == P_PRE);
        end
    end

    generate
        for (genvar g = 0; g < N_SW; g++) begin : g_ch
            debounce_ch #(
                .STABLE_TICKS (STABLE_TICKS),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .i_tick (r_tick),
                .i_sw   (sw_bus.sw_in[g]),
                .o_out  (w_ch[g])
            );
            assign w_level[g] = w_ch[g].level;
            assign w_rise[g]  = w_ch[g].rise;
            assign w_fall[g]  = w_ch[g].fall;
        end
    endgenerate

    assign sw_bus.sw_level = w_level;
    assign sw_bus.sw_rise  = w_rise;
    assign sw_bus.sw_fall  = w_fall;
    assign sw_bus.tick     = r_tick;

endmodule

// File: tb/tb_sw_debounce_edge.sv
// Bench for sw_debounce_edge: directed scenarios plus random chatter against a run-length reference model.
module tb_sw_debounce_edge;
    localparam int N  = 3;
    localparam int T  = 4;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic rst;
    int   ncmp = 0;
    int   nerr = 0;

    sw_debounce_edge_if #(.N_SW(N)) sw_bus ();

    sw_debounce_edge #(
        .N_SW(N), .TICK_DIV(T), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_bus (sw_bus)
    );

    always #5 clk = ~clk;

    // Reference: level flips on a tick edge once the synced value has disagreed continuously
    // over a span containing ST tick edges; tick edges are those where edges-since-reset % T == 0.
    int          e = 0;
    logic [N-1:0] h1 = '0, h2 = '0, prev_sync;
    logic [N-1:0] m_level = '0, m_rise = '0, m_fall = '0;
    logic         m_tick = 1'b0;
    bit           run_on [N];
    int           run_start [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = 0; h1 = '0; h2 = '0;
            m_level = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0;
            for (int c = 0; c < N; c++) run_on[c] = 1'b0;
        end else begin
            e++;
            prev_sync = h2;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N; c++) begin
                if (prev_sync[c] == m_level[c]) begin
                    run_on[c] = 1'b0;
                end else begin
                    if (!run_on[c]) begin
                        run_on[c]    = 1'b1;
                        run_start[c] = e;
                    end
                    if ((e % T == 0) && ((e / T) - ((run_start[c] - 1) / T) >= ST)) begin
                        m_level[c] = ~m_level[c];
                        m_rise[c]  = m_level[c];
                        m_fall[c]  = ~m_level[c];
                        run_on[c]  = 1'b0;
                    end
                end
            end
            h2 = h1;
            h1 = ~sw_bus.sw_in;
            m_tick = (e % T == T - 1);
        end
    end

    logic [3*N:0] obs, expv;
    assign obs  = {sw_bus.sw_level, sw_bus.sw_rise, sw_bus.sw_fall, sw_bus.tick};
    assign expv = {m_level, m_rise, m_fall, m_tick};

    task automatic test_reset();
        int ticks = 0;
        rst = 1'b1;
        sw_bus.sw_in = '1;
        repeat (3) begin
            @(negedge clk);
            ncmp++;
            if (obs !== '0) begin
                nerr++;
                $display("FAIL reset_outputs got=%b want=0", obs);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ticks += int'(sw_bus.tick);
            ncmp++;
            if (obs !== expv) begin
                nerr++;
                $display("FAIL freerun_model cyc=%0d got=%b want=%b", k, obs, expv);
            end
        end
        ncmp++;
        if (ticks != 10) begin
            nerr++;
            $display("FAIL tick_count got=%0d want=10", ticks);
        end
        ncmp++;
        if (sw_bus.sw_level !== 3'b000) begin
            nerr++;
            $display("FAIL idle_level got=%b want=000", sw_bus.sw_level);
        end
    endtask

    task automatic test_press();
        int first = -1, nr = 0, nf = 0;
        bit coinc = 1'b0;
        @(negedge clk);
        sw_bus.sw_in[0] = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            nr += int'(sw_bus.sw_rise[0]);
            nf += int'(sw_bus.sw_fall[0]);
            if (first < 0 && sw_bus.sw_level[0]) begin
                first = k;
                coinc = sw_bus.sw_rise[0];
            end
            ncmp++;
            if (obs !== expv) begin
                nerr++;
                $display("FAIL press_model cyc=%0d got=%b want=%b", k, obs, expv);
            end
        end
        ncmp++;
        if (first < 11 || first > 14) begin
            nerr++;
            $display("FAIL press_latency got=%0d want=11..14", first);
        end
        ncmp++;
        if (nr != 1 || nf != 0 || !coinc) begin
            nerr++;
            $display("FAIL press_pulses got rise=%0d fall=%0d coinc=%0d want 1 0 1", nr, nf, coinc);
        end
    endtask

    task automatic test_release();
        int first = -1, nr = 0, nf = 0;
        @(negedge clk);
        sw_bus.sw_in[0] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            nr += int'(sw_bus.sw_rise[0]);
            nf += int'(sw_bus.sw_fall[0]);
            if (first < 0 && !sw_bus.sw_level[0]) first = k;
            ncmp++;
            if (obs !== expv) begin
                nerr++;
                $display("FAIL release_model cyc=%0d got=%b want=%b", k, obs, expv);
            end
        end
        ncmp++;
        if (first < 11 || first > 14 || nf != 1 || nr != 0) begin
            nerr++;
            $display("FAIL release got lat=%0d fall=%0d rise=%0d want 11..14 1 0", first, nf, nr);
        end
    endtask

    task automatic test_bounce();
        int nr = 0, nf = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k < 20 && k % 3 == 0) sw_bus.sw_in[0] = ~sw_bus.sw_in[0];
            else if (k >= 20)         sw_bus.sw_in[0] = 1'b0;
            nr += int'(sw_bus.sw_rise[0]);
            nf += int'(sw_bus.sw_fall[0]);
            ncmp++;
            if (obs !== expv) begin
                nerr++;
                $display("FAIL bounce_model cyc=%0d got=%b want=%b", k, obs, expv);
            end
        end
        ncmp++;
        if (nr != 1 || nf != 0 || sw_bus.sw_level[0] !== 1'b1) begin
            nerr++;
            $display("FAIL bounce got rise=%0d fall=%0d lvl=%b want 1 0 1", nr, nf, sw_bus.sw_level[0]);
        end
        sw_bus.sw_in[0] = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_glitch();
        int np = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            sw_bus.sw_in[1] = !(k < 6);
            np += int'(sw_bus.sw_rise[1]) + int'(sw_bus.sw_fall[1]);
            ncmp++;
            if (obs !== expv) begin
                nerr++;
                $display("FAIL glitch_model cyc=%0d got=%b want=%b", k, obs, expv);
            end
        end
        ncmp++;
        if (np != 0 || sw_bus.sw_level[1] !== 1'b0) begin
            nerr++;
            $display("FAIL glitch got pulses=%0d lvl=%b want 0 0", np, sw_bus.sw_level[1]);
        end
    endtask

    task automatic test_reset_midcount();
        bit both = 1'b0;
        @(negedge clk);
        sw_bus.sw_in[0] = 1'b0;
        sw_bus.sw_in[2] = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ncmp++;
            if (obs !== '0) begin
                nerr++;
                $display("FAIL midreset_outputs got=%b want=0", obs);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (sw_bus.sw_rise[0] && sw_bus.sw_rise[2]) both = 1'b1;
            ncmp++;
            if (obs !== expv) begin
                nerr++;
                $display("FAIL midreset_model cyc=%0d got=%b want=%b", k, obs, expv);
            end
        end
        ncmp++;
        if (!both || sw_bus.sw_level !== 3'b101) begin
            nerr++;
            $display("FAIL midreset_rise got both=%0d lvl=%b want 1 101", both, sw_bus.sw_level);
        end
        sw_bus.sw_in = '1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                int c = $urandom_range(0, N - 1);
                sw_bus.sw_in[c] = ~sw_bus.sw_in[c];
            end
            ncmp++;
            if (obs !== expv || (sw_bus.sw_rise & sw_bus.sw_fall) !== '0) begin
                nerr++;
                $display("FAIL random_model cyc=%0d got=%b want=%b", k, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_glitch();
        test_reset_midcount();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
